// File: rtl/stopwatch_ctrl.sv
// Seconds stopwatch (00-59, BCD) with start/stop/clear commands and a
// programmable prescaler that sets the length of one "second" in clk cycles.
module stopwatch_ctrl #(
    parameter logic [23:0] MAX_COUNT = 24'd10_000_000
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       cmd_start,
    input  logic       cmd_stop,
    input  logic       cmd_clear,
    input  logic [7:0] period_in,
    output logic [3:0] ones,
    output logic [3:0] tens,
    output logic       running,
    output logic       tick,
    output logic       wrap
);

    typedef enum logic [1:0] {IDLE, RUN, PAUSE} state_t;

    state_t      state;
    logic        start_q, stop_q, clear_q;
    logic        start_e, stop_e, clear_e;
    logic [23:0] presc;
    logic [23:0] compare;
    logic [23:0] period_cmp;
    logic        terminal;

    // A command counts once per low-to-high transition, however long it is held.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            start_q <= 1'b0;
            stop_q  <= 1'b0;
            clear_q <= 1'b0;
        end else begin
            start_q <= cmd_start;
            stop_q  <= cmd_stop;
            clear_q <= cmd_clear;
        end
    end

    assign start_e = cmd_start & ~start_q;
    assign stop_e  = cmd_stop  & ~stop_q;
    assign clear_e = cmd_clear & ~clear_q;

    assign period_cmp = (period_in == 8'd0) ? MAX_COUNT : {6'b0, period_in, 10'b0};
    assign terminal   = (state == RUN) && (presc == compare);
    assign running    = (state == RUN);

    // Clear outranks everything; within RUN the prescaler/digit update still
    // happens on a stop cycle so a coincident terminal count is not lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            presc   <= 24'd0;
            compare <= MAX_COUNT;
            ones    <= 4'd0;
            tens    <= 4'd0;
            tick    <= 1'b0;
            wrap    <= 1'b0;
        end else begin
            tick <= 1'b0;
            wrap <= 1'b0;
            if (clear_e) begin
                state <= IDLE;
                presc <= 24'd0;
                ones  <= 4'd0;
                tens  <= 4'd0;
            end else begin
                case (state)
                    IDLE: begin
                        if (start_e && !stop_e) begin
                            state   <= RUN;
                            compare <= period_cmp;
                            presc   <= 24'd0;
                        end
                    end
                    RUN: begin
                        if (terminal) begin
                            presc <= 24'd0;
                            tick  <= 1'b1;
                            if (ones == 4'd9) begin
                                ones <= 4'd0;
                                if (tens == 4'd5) begin
                                    tens <= 4'd0;
                                    wrap <= 1'b1;
                                end else begin
                                    tens <= tens + 4'd1;
                                end
                            end else begin
                                ones <= ones + 4'd1;
                            end
                        end else begin
                            presc <= presc + 24'd1;
                        end
                        if (stop_e) state <= PAUSE;
                    end
                    PAUSE: begin
                        // Resume keeps the compare latched at the original start.
                        if (start_e && !stop_e) state <= RUN;
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule
